work_dispatch_rr: RTL and testbench
===================================

# work_dispatch_rr

Parametrised pixel-work dispatcher for the Julia renderer. It raster-scans a configurable frame, issuing one pixel coordinate per clock to whichever Julia worker is free. Workers are chosen round-robin, so low-index workers are not starved. A pending-mask handshake prevents double dispatch, and the block drains outstanding work before signalling frame completion. It sits between the frame controller (start/abort) and the worker array.

## Interface
- NUM_WORKERS, 16: number of worker channels (2..32).
- COORD_W, 10: coordinate width.
- X_MAX, 639: last x of a row.
- Y_MAX, 479: last y of a frame.

- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  cancel frame; wins over everything else.
- worker_ready  in  NUM_WORKERS  worker i idle and able to accept a pixel.
- worker_start  out  NUM_WORKERS  one-hot, one-cycle pulse granting a pixel.
- x_reg  out  NUM_WORKERS*COORD_W  per-worker latched x; slice i is [i*COORD_W +: COORD_W].
- y_reg  out  NUM_WORKERS*COORD_W  per-worker latched y.
- incr  out  1  pulses in the same cycle as any worker_start.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the frame is fully drained.

## Operation
- All outputs are registered. On reset, all outputs are 0, the state is IDLE, the pending mask is 0, and the RR pointer is NUM_WORKERS-1.
- **IDLE**
  - If start=1 and abort=0: clear the scan counter to (0,0), clear all x_reg/y_reg and the pending mask, then go to RUN.
- **RUN**, evaluated every cycle:
  - eligible = worker_ready & ~pending.
  - Grant the first set eligible bit, searching from pointer+1 upward and wrapping.
  - On a grant i:
    - worker_start[i]=1 and incr=1.
    - x_reg[i], y_reg[i] take the current scan (x,y).
    - pending[i] is set and pointer becomes i.
    - The scan advances: x increments; when x==X_MAX, x wraps to 0 and y increments.
  - If the granted pixel is (X_MAX,Y_MAX), go to DRAIN instead of advancing.
  - No eligible worker means no grant and no advance.
- **Pending handshake**
  - pending[i] clears in any cycle where worker_ready[i]=0.
  - Worker contract: after worker_start, ready must drop for at least one cycle.
  - A worker holding ready high is never re-granted.
- **DRAIN**
  - No grants are made.
  - When pending==0 and worker_ready is all ones, go to DONE.
- **DONE**
  - frame_done=1 for one cycle, then go to IDLE. x_reg/y_reg keep their last values.
- **abort=1 in any state**
  - Next state is IDLE. Pending and worker_start are cleared and no frame_done is issued.
  - A grant computed in the abort cycle is suppressed.
- start outside IDLE is ignored.
- Simultaneous set and clear of the same pending bit cannot occur, because a grant requires ready=1.

## Timing
- start sampled at edge k puts the block in RUN after k. The earliest worker_start is high after edge k+1.
- Sustained throughput is 1 pixel/clock while any worker is eligible.
- A frame requires exactly (X_MAX+1)*(Y_MAX+1) grants (307200 at defaults).
- The last grant is followed by ≥1 DRAIN cycle, then DONE, then IDLE.
- Coordinates are valid on x_reg[i] in the same cycle worker_start[i] is high, and are held until worker i's next grant.

## Structure
- Package `dispatch_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE) as a 2-bit typedef;
  - the default X_MAX/Y_MAX/COORD_W constants.
- Sub-module `xy_scan` (parametrised COORD_W, X_MAX, Y_MAX) provides:
  - inputs: clr, inc;
  - outputs: x, y, last (x==X_MAX && y==Y_MAX).
- The RR arbiter is an in-module function over a doubled request vector; it does not justify a separate file.

## Test plan
- **Single worker:** NUM_WORKERS=2, X_MAX=3, Y_MAX=1, only worker 0 toggles ready (high, low 1 cycle after start, high 3 cycles later) -> 8 grants to worker 0 in raster order (0,0),(1,0)..(3,1), then frame_done once.
- **Round-robin:** all 16 ready constantly after each drop -> grants cycle 0,1,..,15,0; no worker is granted twice before all others; incr count equals grant count.
- **Held-high worker:** worker 3 keeps ready high after its grant -> it is never re-granted; DRAIN stalls until ready drops and rises.
- **Abort mid-frame:** abort after 5 grants -> IDLE next cycle, no frame_done, busy=0; a following start restarts at (0,0).
- **Start/abort edge cases:** start during RUN is ignored; start and abort in the same cycle -> the block stays IDLE.
- **Reset mid-RUN:** all outputs return to 0 asynchronously; the first grant after a new start goes to worker 0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and default frame geometry for the pixel-work dispatcher.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_X_MAX   = 639;
    localparam int DEF_Y_MAX   = 479;

endpackage

// File: rtl/xy_scan.sv
// Raster-scan coordinate counter: x runs 0..X_MAX, then wraps and bumps y.
module xy_scan
    import dispatch_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int Y_MAX   = DEF_Y_MAX
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clr,
    input  logic               inc,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    // Scan position; y never wraps because the dispatcher stops on the last pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (inc) begin
            if (r_x == XM) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = (r_x == XM) && (r_y == YM);

endmodule

// File: rtl/work_dispatch_rr.sv
// Round-robin pixel dispatcher: hands one raster coordinate per clock to a
// free Julia worker, tracks in-flight work and drains before frame_done.
module work_dispatch_rr
    import dispatch_pkg::*;
#(
    parameter int NUM_WORKERS = 16,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MAX       = DEF_Y_MAX
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_WORKERS-1:0]         worker_ready,
    output logic [NUM_WORKERS-1:0]         worker_start,
    output logic [NUM_WORKERS*COORD_W-1:0] x_reg,
    output logic [NUM_WORKERS*COORD_W-1:0] y_reg,
    output logic                           incr,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int PTR_W = $clog2(NUM_WORKERS);

    state_t                         r_state, w_nxt;
    logic [NUM_WORKERS-1:0]         r_pend, r_ws;
    logic [PTR_W-1:0]               r_ptr, w_gidx;
    logic [NUM_WORKERS*COORD_W-1:0] r_x, r_y;
    logic                           r_incr, r_busy, r_done;
    logic [NUM_WORKERS-1:0]         w_elig, w_gnt, w_fire;
    logic                           w_clr, w_inc, w_last;
    logic [COORD_W-1:0]             w_sx, w_sy;

    // First set request strictly after ptr, wrapping; the doubled vector
    // turns the wrap into a plain linear search over ptr+1..ptr+N.
    function automatic logic [NUM_WORKERS-1:0] rr_grant(
        input logic [NUM_WORKERS-1:0] req,
        input logic [PTR_W-1:0]       ptr
    );
        logic [2*NUM_WORKERS-1:0] dbl;
        logic [2*NUM_WORKERS-1:0] g2;
        logic                     found;
        dbl   = {req, req};
        g2    = '0;
        found = 1'b0;
        for (int j = 0; j < 2*NUM_WORKERS; j++) begin
            if (!found && (j > int'(ptr)) && (j <= int'(ptr) + NUM_WORKERS) && dbl[j]) begin
                g2[j] = 1'b1;
                found = 1'b1;
            end
        end
        return g2[NUM_WORKERS-1:0] | g2[2*NUM_WORKERS-1:NUM_WORKERS];
    endfunction

    xy_scan #(
        .COORD_W (COORD_W),
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX)
    ) u_scan (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (w_clr),
        .inc   (w_inc),
        .x     (w_sx),
        .y     (w_sy),
        .last  (w_last)
    );

    assign w_elig = worker_ready & ~r_pend;
    assign w_gnt  = rr_grant(w_elig, r_ptr);

    // Encode the one-hot grant into the next pointer value.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (w_gnt[i]) w_gidx = PTR_W'(i);
        end
    end

    // Next state and per-cycle actions; abort overrides everything last.
    always_comb begin
        w_nxt  = r_state;
        w_fire = '0;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr = 1'b1;
                    w_nxt = RUN;
                end
            end
            RUN: begin
                if (|w_gnt) begin
                    w_fire = w_gnt;
                    if (w_last) w_nxt = DRAIN;
                    else        w_inc = 1'b1;
                end
            end
            DRAIN: begin
                if ((r_pend == '0) && (&worker_ready)) w_nxt = DONE;
            end
            DONE: w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (abort) begin
            w_nxt  = IDLE;
            w_fire = '0;
            w_clr  = 1'b0;
            w_inc  = 1'b0;
        end
    end

    // State, pending mask, RR pointer and registered control outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_ptr   <= PTR_W'(NUM_WORKERS-1);
            r_ws    <= '0;
            r_incr  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ws    <= w_fire;
            r_incr  <= |w_fire;
            r_busy  <= (w_nxt != IDLE);
            r_done  <= (w_nxt == DONE);
            // A dropped ready retires the outstanding pixel; a grant marks it.
            if (abort || w_clr) r_pend <= '0;
            else                r_pend <= (r_pend & worker_ready) | w_fire;
            if (|w_fire) r_ptr <= w_gidx;
        end
    end

    // Per-worker coordinate latches, loaded on that worker's grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                if (w_fire[i]) begin
                    r_x[i*COORD_W +: COORD_W] <= w_sx;
                    r_y[i*COORD_W +: COORD_W] <= w_sy;
                end
            end
        end
    end

    assign worker_start = r_ws;
    assign x_reg        = r_x;
    assign y_reg        = r_y;
    assign incr         = r_incr;
    assign busy         = r_busy;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_work_dispatch_rr.sv
// Directed bench for work_dispatch_rr on a small 8x4 frame with 16 workers.
module tb_work_dispatch_rr;

    localparam int N = 16, CW = 4, XM = 7, YM = 3, NPIX = (XM+1)*(YM+1);

    logic          clk = 1'b0, n_rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [N-1:0]  worker_ready = '0;
    logic [N-1:0]  worker_start;
    logic [N*CW-1:0] x_reg, y_reg;
    logic          incr, busy, frame_done;

    always #5 clk = ~clk;

    work_dispatch_rr #(.NUM_WORKERS(N), .COORD_W(CW), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .worker_ready(worker_ready), .worker_start(worker_start),
        .x_reg(x_reg), .y_reg(y_reg), .incr(incr), .busy(busy), .frame_done(frame_done)
    );

    int n_cmp = 0, n_fail = 0;

    // worker model and observation state
    logic [N-1:0] en = '0, hold = '0;
    int  cnt [N];
    int  lat = 1;
    bit  auto_m = 0, raise_end = 0;
    int  cyc, gcnt, incr_cnt, done_cnt, bad_oh, first_g_cyc, last_g_cyc, done_cyc;
    int  gidx [64], gx [64], gy [64];

    typedef struct packed {
        logic [15:0] rdy;
        logic        st;
        logic [15:0] ws;
        logic [3:0]  ex;
        logic [3:0]  ey;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; gcnt = 0; incr_cnt = 0; done_cnt = 0; bad_oh = 0;
        first_g_cyc = 0; last_g_cyc = 0; done_cyc = 0;
    endtask

    // One clock: sample outputs #1 after the edge, then update the worker model.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (worker_start != '0) begin
            if (!$onehot(worker_start)) bad_oh++;
            if (gcnt == 0) first_g_cyc = cyc;
            for (int i = 0; i < N; i++) begin
                if (worker_start[i] && gcnt < 64) begin
                    gidx[gcnt] = i;
                    gx[gcnt]   = int'(x_reg[i*CW +: CW]);
                    gy[gcnt]   = int'(y_reg[i*CW +: CW]);
                end
            end
            gcnt++;
            last_g_cyc = cyc;
        end
        if (incr) incr_cnt++;
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (raise_end && gcnt >= NPIX) en = '1;
        if (auto_m) begin
            for (int i = 0; i < N; i++) begin
                if (worker_start[i] && !hold[i]) cnt[i] = lat;
                if (cnt[i] > 0) begin worker_ready[i] = 1'b0; cnt[i]--; end
                else worker_ready[i] = en[i];
            end
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; worker_ready = '0;
        en = '0; hold = '0; auto_m = 0; raise_end = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic go();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic run_frame(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) step();
    endtask

    initial begin
        int bad, k3;
        tbl[0]  = '{16'h0001, 1'b0, 16'h0001, 4'd0, 4'd0};
        tbl[1]  = '{16'h0003, 1'b0, 16'h0002, 4'd1, 4'd0};
        tbl[2]  = '{16'h0003, 1'b0, 16'h0000, 4'd0, 4'd0};
        tbl[3]  = '{16'h0000, 1'b0, 16'h0000, 4'd0, 4'd0};
        tbl[4]  = '{16'h0003, 1'b0, 16'h0001, 4'd2, 4'd0};
        tbl[5]  = '{16'h8002, 1'b0, 16'h0002, 4'd3, 4'd0};
        tbl[6]  = '{16'h8001, 1'b0, 16'h8000, 4'd4, 4'd0};
        tbl[7]  = '{16'h8001, 1'b0, 16'h0001, 4'd5, 4'd0};
        tbl[8]  = '{16'h0010, 1'b1, 16'h0010, 4'd6, 4'd0};
        tbl[9]  = '{16'h0020, 1'b0, 16'h0020, 4'd7, 4'd0};
        tbl[10] = '{16'h0040, 1'b0, 16'h0040, 4'd0, 4'd1};
        tbl[11] = '{16'h0000, 1'b0, 16'h0000, 4'd0, 4'd0};
        for (int i = 0; i < N; i++) cnt[i] = 0;
        clr_stats();

        // asynchronous reset, before any clock edge
        #1 n_rst = 1'b0;
        #2;
        chk("rst_ws", 32'(worker_start), 0);
        chk("rst_xy", 32'(|{x_reg, y_reg}), 0);
        chk("rst_ctl", 32'({incr, busy, frame_done}), 0);
        do_reset();

        // idle: ready workers are not granted without start
        clr_stats();
        worker_ready = '1;
        repeat (3) step();
        chk("idle_nogrant", gcnt, 0);
        chk("idle_busy", 32'(busy), 0);
        worker_ready = '0;

        // table: arbiter, pending handshake, scan, start ignored in RUN
        go();
        chk("run_busy", 32'(busy), 1);
        for (int v = 0; v < 12; v++) begin
            worker_ready = tbl[v].rdy;
            start = tbl[v].st;
            step();
            start = 1'b0;
            chk($sformatf("vec%0d_ws", v), 32'(worker_start), 32'(tbl[v].ws));
            chk($sformatf("vec%0d_incr", v), 32'(incr), 32'(|tbl[v].ws));
            for (int i = 0; i < N; i++) begin
                if (tbl[v].ws[i]) begin
                    chk($sformatf("vec%0d_x", v), 32'(x_reg[i*CW +: CW]), 32'(tbl[v].ex));
                    chk($sformatf("vec%0d_y", v), 32'(y_reg[i*CW +: CW]), 32'(tbl[v].ey));
                end
            end
        end

        // abort with an eligible worker: grant suppressed, back to IDLE
        worker_ready = 16'h0080; abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ws", 32'(worker_start), 0);
        chk("abort_incr", 32'(incr), 0);
        worker_ready = '0;
        repeat (3) step();
        chk("abort_nodone", done_cnt, 0);

        // start and abort together: stays IDLE
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        step();
        chk("sa_busy2", 32'(busy), 0);

        // restart clears latches and scans from (0,0)
        go();
        chk("restart_busy", 32'(busy), 1);
        chk("restart_clr_y6", 32'(y_reg[6*CW +: CW]), 0);
        worker_ready = 16'h0100; step();
        chk("restart_ws", 32'(worker_start), 32'h0100);
        chk("restart_x", 32'(x_reg[8*CW +: CW]), 0);
        chk("restart_y", 32'(y_reg[8*CW +: CW]), 0);

        // single worker: full frame on worker 0, others come up in DRAIN
        do_reset(); clr_stats();
        en = 16'h0001; lat = 3; auto_m = 1; raise_end = 1; worker_ready = en;
        go();
        run_frame(600);
        chk("sw_grants", gcnt, NPIX);
        bad = 0;
        for (int k = 0; k < NPIX && k < gcnt; k++)
            if (gidx[k] != 0 || gx[k] != k % (XM+1) || gy[k] != k / (XM+1)) bad++;
        chk("sw_raster", bad, 0);
        chk("sw_incr", incr_cnt, NPIX);
        chk("sw_done", done_cnt, 1);
        chk("sw_drain_gap", 32'(done_cyc - last_g_cyc >= 2), 1);
        step();
        chk("sw_idle_busy", 32'(busy), 0);
        chk("sw_done_pulse", done_cnt, 1);

        // round-robin: all workers, one-cycle ready drop
        do_reset(); clr_stats();
        en = '1; lat = 1; auto_m = 1; worker_ready = '1;
        go();
        run_frame(200);
        chk("rr_grants", gcnt, NPIX);
        bad = 0;
        for (int k = 0; k < NPIX && k < gcnt; k++) if (gidx[k] != k % N) bad++;
        chk("rr_order", bad, 0);
        chk("rr_incr", incr_cnt, gcnt);
        chk("rr_onehot", bad_oh, 0);
        chk("rr_thruput", last_g_cyc - first_g_cyc, NPIX-1);
        chk("rr_done", done_cnt, 1);

        // held-high worker 3: granted once, DRAIN stalls until it drops
        do_reset(); clr_stats();
        en = '1; lat = 1; hold[3] = 1'b1; auto_m = 1; worker_ready = '1;
        go();
        for (int c = 0; c < 200 && gcnt < NPIX; c++) step();
        repeat (8) step();
        chk("hold_grants", gcnt, NPIX);
        k3 = 0;
        for (int k = 0; k < NPIX && k < gcnt; k++) if (gidx[k] == 3) k3++;
        chk("hold_w3_once", k3, 1);
        chk("hold_stall", done_cnt, 0);
        chk("hold_busy", 32'(busy), 1);
        hold[3] = 1'b0; cnt[3] = 1;
        run_frame(20);
        chk("hold_done", done_cnt, 1);

        // asynchronous reset in the middle of RUN
        do_reset(); clr_stats();
        en = '1; lat = 1; auto_m = 1; worker_ready = '1;
        go();
        repeat (5) step();
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_ws", 32'(worker_start), 0);
        chk("mid_rst_xy", 32'(|{x_reg, y_reg}), 0);
        chk("mid_rst_ctl", 32'({incr, busy, frame_done}), 0);
        do_reset(); clr_stats();
        en = '1; lat = 1; auto_m = 1; worker_ready = '1;
        go();
        step();
        chk("post_rst_grants", gcnt, 1);
        chk("post_rst_w0", 32'(worker_start), 32'h0001);
        chk("post_rst_xy", 32'(|{x_reg[0 +: CW], y_reg[0 +: CW]}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
